// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and feeder state encodings used by the transmit path
// and by the future receive-side buffer.
package uart_tx_fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        GAP     = 2'd3
    } feed_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with registered count/full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Full is judged on the registered count, so a same-cycle pop never admits a write.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Flags are derived from the pre-update count so they land on the same edge.
            case ({push, pop})
                2'b10: begin
                    count <= count + CW'(1);
                    full  <= (count == CW'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - CW'(1);
                    full  <= 1'b0;
                    empty <= (count == CW'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus go/bsy handshake feeder in front of the UART transmitter.
// Define UART_TX_FIFO_OVF_EN to enable the sticky overflow flag.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BYTE_W-1:0]       wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_go,
    input  logic                    tx_bsy,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    feed_state_t        state;
    logic               pop;
    logic [BYTE_W-1:0]  rd_data;

    assign pop = (state == IDLE) && !empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Feeder: tx_data is loaded only in IDLE, so it holds for the whole time tx_go is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_go   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= rd_data;
                        tx_go   <= 1'b1;
                        state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_bsy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_bsy) begin
                        tx_go <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky drop indicator; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a negedge transmitter model (BIT_TIME 4).
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int BIT_TIME = 4;
    localparam int FRAME    = 10 * BIT_TIME;
`ifdef UART_TX_FIFO_OVF_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_go;
    logic       tx_bsy;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    // transmitter model state and statistics
    logic       m_bsy = 1'b0;
    int         m_cnt = 0;
    logic       m_wait_low = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_shift = 8'h00;
    bit         hold = 1'b0;
    bit         stats_clr = 1'b0;
    int         idle_cnt = 0;
    int         max_gap = 0;
    bit         seen_frame = 1'b0;
    int         go_low_run = 0;
    int         min_go_low = 1000;
    bit         seen_go = 1'b0;
    int         stable_err = 0;

    assign tx_bsy = m_bsy;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .tx_data (tx_data),
        .tx_go   (tx_go),
        .tx_bsy  (tx_bsy),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Transmitter: starts on go at a negedge, samples tx_data mid-bit, needs go low before restarting.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_bsy      <= 1'b0;
            m_cnt      <= 0;
            m_wait_low <= 1'b0;
        end else begin
            if (stats_clr) begin
                max_gap    <= 0;
                seen_frame <= 1'b0;
                min_go_low <= 1000;
                seen_go    <= 1'b0;
                go_low_run <= 0;
                stable_err <= 0;
            end else if (tx_go) begin
                if (seen_go && go_low_run > 0 && go_low_run < min_go_low) min_go_low <= go_low_run;
                go_low_run <= 0;
                seen_go    <= 1'b1;
            end else begin
                go_low_run <= go_low_run + 1;
            end

            if (!m_bsy) begin
                idle_cnt <= idle_cnt + 1;
                if (!tx_go) begin
                    m_wait_low <= 1'b0;
                end else if (!m_wait_low && !hold) begin
                    m_bsy   <= 1'b1;
                    m_cnt   <= 0;
                    m_data  <= tx_data;
                    m_shift <= 8'h00;
                    if (!stats_clr && seen_frame && idle_cnt + 1 > max_gap) max_gap <= idle_cnt + 1;
                    seen_frame <= 1'b1;
                end
            end else begin
                if (tx_data !== m_data && !stats_clr) stable_err <= stable_err + 1;
                for (int b = 0; b < 8; b++) begin
                    if (m_cnt == (b + 1) * BIT_TIME + BIT_TIME / 2) m_shift[b] <= tx_data[b];
                end
                if (m_cnt == FRAME - 1) begin
                    m_bsy      <= 1'b0;
                    m_wait_low <= 1'b1;
                    idle_cnt   <= 0;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_unexpected: got %02h want none", m_shift);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (m_shift !== exp_b) begin
                            miscompares++;
                            $display("FAIL frame_data: got %02h want %02h", m_shift, exp_b);
                        end
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        @(negedge clk);
        #1;
        stats_clr = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            step();
            n++;
        end
        ok = (exp_q.size() == 0);
        exp_q.delete();
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL reset_tx_go: got %b want 0", tx_go); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_single();
        bit ok;
        int n;
        clear_stats();
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        step();
        wr_en = 1'b0;
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count_k: got %0d want 1", count); end
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL single_go_k: got %b want 0", tx_go); end
        step();
        vectors++; if (tx_go !== 1'b1) begin miscompares++; $display("FAIL single_go_k1: got %b want 1", tx_go); end
        vectors++; if (tx_data !== 8'h55) begin miscompares++; $display("FAIL single_data_k1: got %02h want 55", tx_data); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL single_count_k1: got %0d want 0", count); end
        n = 0;
        while (tx_go === 1'b1 && n < 200) begin step(); n++; end
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL single_go_fall: got %b want 0", tx_go); end
        step();
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL single_go_low2: got %b want 0", tx_go); end
        wait_drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_drain: got pending frames want none"); end
        vectors++; if (stable_err !== 0) begin miscompares++; $display("FAIL single_stable: got %0d changes want 0", stable_err); end
    endtask

    task automatic test_burst();
        bit ok;
        bit any_full;
        any_full = 1'b0;
        clear_stats();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
            step();
            if (full === 1'b1) any_full = 1'b1;
        end
        wr_en = 1'b0;
        vectors++; if (any_full !== 1'b0) begin miscompares++; $display("FAIL burst_full: got %b want 0", any_full); end
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL burst_count: got %0d want 15", count); end
        wait_drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL burst_drain: got pending frames want none"); end
        vectors++; if (max_gap > 4) begin miscompares++; $display("FAIL burst_gap: got %0d want <=4", max_gap); end
        vectors++; if (min_go_low < 2) begin miscompares++; $display("FAIL burst_go_low: got %0d want >=2", min_go_low); end
        vectors++; if (stable_err !== 0) begin miscompares++; $display("FAIL burst_stable: got %0d changes want 0", stable_err); end
    endtask

    task automatic test_overflow_and_full_pop();
        bit ok;
        int n;
        hold = 1'b1;
        wr_en = 1'b1; wr_data = 8'h80; exp_q.push_back(8'h80);
        step();
        wr_en = 1'b0;
        step();
        vectors++; if (tx_go !== 1'b1) begin miscompares++; $display("FAIL ovf_first_go: got %b want 1", tx_go); end
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h90 + i);
            if (i < 16) exp_q.push_back(8'(8'h90 + i));
            step();
        end
        wr_en = 1'b0;
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ovf_count: got %0d want 16", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
        vectors++; if (ovf !== OVF_EXP) begin miscompares++; $display("FAIL ovf_set: got %b want %b", ovf, OVF_EXP); end
        ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        vectors++; if (ovf !== OVF_EXP) begin miscompares++; $display("FAIL ovf_set_wins: got %b want %b", ovf, OVF_EXP); end
        step();
        ovf_clr = 1'b0;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ovf_count_hold: got %0d want 16", count); end

        // release the transmitter and write into the full FIFO on the exact pop edge
        hold = 1'b0;
        n = 0;
        while (tx_go === 1'b1 && n < 200) begin step(); n++; end
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL fullpop_go_fall: got %b want 0", tx_go); end
        step();
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL fullpop_count: got %0d want 15", count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fullpop_full: got %b want 0", full); end
        vectors++; if (tx_go !== 1'b1) begin miscompares++; $display("FAIL fullpop_go: got %b want 1", tx_go); end
        vectors++; if (ovf !== OVF_EXP) begin miscompares++; $display("FAIL fullpop_ovf: got %b want %b", ovf, OVF_EXP); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        wait_drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL fullpop_drain: got pending frames want none"); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        n = 0;
        while (tx_bsy !== 1'b1 && n < 50) begin step(); n++; end
        vectors++; if (tx_bsy !== 1'b1) begin miscompares++; $display("FAIL rstmid_bsy: got %b want 1", tx_bsy); end
        vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL rstmid_queued: got %0d want 5", count); end
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        vectors++; if (tx_go !== 1'b0) begin miscompares++; $display("FAIL rstmid_go: got %b want 0", tx_go); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty: got %b want 1", empty); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %02h want 00", tx_data); end
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        wait_drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_drain: got pending frames want none"); end
    endtask

    task automatic test_wrap();
        bit ok;
        int fails;
        fails = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr_en = 1'b1; wr_data = 8'((r * DEPTH + i) * 7); exp_q.push_back(8'((r * DEPTH + i) * 7));
                step();
            end
            wr_en = 1'b0;
            wait_drain(ok);
            if (!ok) fails++;
        end
        vectors++; if (fails !== 0) begin miscompares++; $display("FAIL wrap_drain: got %0d stalled rounds want 0", fails); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow_and_full_pop();
        test_reset_mid_frame();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
